// File: rtl/rf_xfer_seq.sv
// Register-file transfer sequencer: turns LDI / MOV / RD commands into registered
// one-hot select, re and we strobes with a valid/ready command handshake.
module rf_xfer_seq #(
    parameter int W      = 8,
    parameter int RD_LAT = 1   // 1..4 cycles of re before p is sampled
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [2:0]   cmd_dst,
    input  logic [2:0]   cmd_src,
    input  logic [W-1:0] cmd_imm,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_data,
    output logic         err,
    output logic [W-1:0] d,
    output logic         as,
    output logic         bs,
    output logic         cs,
    output logic         ds,
    output logic         fs,
    output logic         re,
    output logic         we,
    input  logic [W-1:0] p
);

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [1:0] OP_MOV = 2'b10;
    localparam logic [1:0] OP_RD  = 2'b11;

    typedef enum logic [1:0] {IDLE, RSEL, WR, RSP} state_t;

    state_t       state, state_n;
    logic [2:0]   cnt, cnt_n;
    logic [1:0]   op_q, op_n;
    logic [2:0]   dst_q, dst_n, src_q, src_n;
    logic [W-1:0] cap, cap_n;
    logic [W-1:0] rsp_data_n, d_n;
    logic [4:0]   sel, sel_n;
    logic         cmd_ready_n, rsp_valid_n, err_n, re_n, we_n, accept;

    // Codes 5..7 map to no select at all.
    function automatic logic [4:0] onehot(input logic [2:0] code);
        return (code < 3'd5) ? (5'b00001 << code) : 5'b00000;
    endfunction

    function automatic logic legal(input logic [2:0] code);
        return code < 3'd5;
    endfunction

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        op_n       = op_q;
        dst_n      = dst_q;
        src_n      = src_q;
        cap_n      = cap;
        rsp_data_n = rsp_data;
        err_n      = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    op_n  = cmd_op;
                    dst_n = cmd_dst;
                    src_n = cmd_src;
                    case (cmd_op)
                        OP_LDI: begin
                            if (legal(cmd_dst)) begin
                                state_n = WR;
                                cap_n   = cmd_imm;
                            end else begin
                                err_n = 1'b1;
                            end
                        end
                        OP_MOV: begin
                            if (legal(cmd_dst) && legal(cmd_src)) begin
                                state_n = RSEL;
                                cnt_n   = 3'(RD_LAT - 1);
                            end else begin
                                err_n = 1'b1;
                            end
                        end
                        OP_RD: begin
                            if (legal(cmd_src)) begin
                                state_n = RSEL;
                                cnt_n   = 3'(RD_LAT - 1);
                            end else begin
                                err_n = 1'b1;
                            end
                        end
                        default: ;  // NOP: consumed with no strobes
                    endcase
                end
            end
            RSEL: begin
                if (cnt == 3'd0) begin
                    cap_n = p;
                    if (op_q == OP_RD) begin
                        rsp_data_n = p;
                        state_n    = RSP;
                    end else begin
                        state_n = WR;
                    end
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            WR:      state_n = IDLE;
            RSP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Outputs are computed from the next state so that every strobe is a flop.
        cmd_ready_n = (state_n == IDLE) && !accept;
        re_n        = (state_n == RSEL);
        we_n        = (state_n == WR);
        rsp_valid_n = (state_n == RSP);
        sel_n       = re_n ? onehot(src_n) : (we_n ? onehot(dst_n) : 5'b00000);
        d_n         = we_n ? cap_n : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= OP_NOP;
            dst_q     <= '0;
            src_q     <= '0;
            cap       <= '0;
            rsp_data  <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            err       <= 1'b0;
            d         <= '0;
            sel       <= '0;
            re        <= 1'b0;
            we        <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            op_q      <= op_n;
            dst_q     <= dst_n;
            src_q     <= src_n;
            cap       <= cap_n;
            rsp_data  <= rsp_data_n;
            cmd_ready <= cmd_ready_n;
            rsp_valid <= rsp_valid_n;
            err       <= err_n;
            d         <= d_n;
            sel       <= sel_n;
            re        <= re_n;
            we        <= we_n;
        end
    end

    assign as = sel[0];
    assign bs = sel[1];
    assign cs = sel[2];
    assign ds = sel[3];
    assign fs = sel[4];

endmodule

// File: tb/tb_rf_xfer_seq.sv
// Directed bench for rf_xfer_seq: two instances (RD_LAT=1 and RD_LAT=3), each with a
// small register-file model attached.
module tb_rf_xfer_seq;

    localparam int W = 8;
    localparam logic [1:0] NOP = 2'b00, LDI = 2'b01, MOV = 2'b10, RD = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] cmd_valid = '0;
    logic [1:0] cmd_ready, rsp_valid, err, re, we, as_s, bs_s, cs_s, ds_s, fs_s;
    logic [1:0]   cmd_op  = NOP;
    logic [2:0]   cmd_dst = '0;
    logic [2:0]   cmd_src = '0;
    logic [W-1:0] cmd_imm = '0;
    logic [1:0][W-1:0] rsp_data, d, p;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [W-1:0] regs [5] = '{default: '0};

        rf_xfer_seq #(.W(W), .RD_LAT(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .rst(rst),
            .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
            .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
            .rsp_valid(rsp_valid[g]), .rsp_data(rsp_data[g]), .err(err[g]),
            .d(d[g]), .as(as_s[g]), .bs(bs_s[g]), .cs(cs_s[g]), .ds(ds_s[g]), .fs(fs_s[g]),
            .re(re[g]), .we(we[g]), .p(p[g])
        );

        always @(posedge clk) begin
            if (we[g]) begin
                if (as_s[g]) regs[0] <= d[g];
                if (bs_s[g]) regs[1] <= d[g];
                if (cs_s[g]) regs[2] <= d[g];
                if (ds_s[g]) regs[3] <= d[g];
                if (fs_s[g]) regs[4] <= d[g];
            end
        end

        assign p[g] = !re[g]  ? '0      :
                      as_s[g] ? regs[0] :
                      bs_s[g] ? regs[1] :
                      cs_s[g] ? regs[2] :
                      ds_s[g] ? regs[3] :
                      fs_s[g] ? regs[4] : '0;
    end

    // {re, we, as, bs, cs, ds, fs}
    function automatic logic [6:0] stb(input int i);
        return {re[i], we[i], as_s[i], bs_s[i], cs_s[i], ds_s[i], fs_s[i]};
    endfunction

    // Advance one clock, sample 1 time unit later, and check the strobe invariants.
    task automatic tick();
        logic [4:0] s;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            s = {as_s[i], bs_s[i], cs_s[i], ds_s[i], fs_s[i]};
            n_cmp++;
            if (!$onehot0(s) || (re[i] && we[i]) || (!re[i] && !we[i] && s != 0) ||
                (!we[i] && d[i] != 0)) begin
                n_bad++;
                $display("FAIL invariant[%0d] got stb=%b d=%0d want legal strobe set", i, stb(i), d[i]);
            end
        end
    endtask

    task automatic set_cmd(input int i, input logic [1:0] op, input logic [2:0] dst,
                           input logic [2:0] src, input logic [W-1:0] imm);
        cmd_valid[i] = 1'b1;
        cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm;
    endtask

    task automatic do_cmd(input int i, input logic [1:0] op, input logic [2:0] dst,
                          input logic [2:0] src, input logic [W-1:0] imm);
        set_cmd(i, op, dst, src, imm);
        tick();
        cmd_valid[i] = 1'b0;
        for (int k = 0; k < 20 && !cmd_ready[i]; k++) tick();
        n_cmp++;
        if (cmd_ready[i] !== 1'b1) begin
            n_bad++;
            $display("FAIL do_cmd_timeout[%0d] got ready=%b want 1", i, cmd_ready[i]);
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({cmd_ready[i], rsp_valid[i], err[i], stb(i)} !== 10'b0 || rsp_data[i] !== 0 || d[i] !== 0) begin
                n_bad++;
                $display("FAIL reset_outputs[%0d] got ready=%b rv=%b err=%b stb=%b rsp=%0d d=%0d want all 0",
                         i, cmd_ready[i], rsp_valid[i], err[i], stb(i), rsp_data[i], d[i]);
            end
        end
        rst = 1'b0;
        n_cmp++;
        if (cmd_ready !== 2'b00) begin
            n_bad++; $display("FAIL ready_before_edge got %b want 00", cmd_ready);
        end
        tick();
        n_cmp++;
        if (cmd_ready !== 2'b11) begin
            n_bad++; $display("FAIL ready_after_release got %b want 11", cmd_ready);
        end
    endtask

    task automatic test_ldi();
        set_cmd(0, LDI, 3'd0, 3'd0, 8'd100);
        tick();
        cmd_valid[0] = 1'b0;
        n_cmp++;
        if (stb(0) !== 7'b0110000 || d[0] !== 8'd100 || cmd_ready[0] !== 1'b0) begin
            n_bad++; $display("FAIL ldi_wr got stb=%b d=%0d ready=%b want 0110000 100 0", stb(0), d[0], cmd_ready[0]);
        end
        tick();
        n_cmp++;
        if (stb(0) !== 7'b0 || d[0] !== 8'd0 || cmd_ready[0] !== 1'b1) begin
            n_bad++; $display("FAIL ldi_done got stb=%b d=%0d ready=%b want 0 0 1", stb(0), d[0], cmd_ready[0]);
        end
        set_cmd(0, RD, 3'd0, 3'd0, 8'd0);
        tick();
        cmd_valid[0] = 1'b0;
        n_cmp++;
        if (stb(0) !== 7'b1010000) begin
            n_bad++; $display("FAIL rd_a_rsel got stb=%b want 1010000", stb(0));
        end
        tick();
        n_cmp++;
        if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 8'd100 || stb(0) !== 7'b0) begin
            n_bad++; $display("FAIL rd_a_rsp got rv=%b data=%0d stb=%b want 1 100 0", rsp_valid[0], rsp_data[0], stb(0));
        end
        tick();
        n_cmp++;
        if (rsp_valid[0] !== 1'b0 || cmd_ready[0] !== 1'b1 || rsp_data[0] !== 8'd100) begin
            n_bad++; $display("FAIL rd_a_end got rv=%b ready=%b data=%0d want 0 1 100", rsp_valid[0], cmd_ready[0], rsp_data[0]);
        end
    endtask

    task automatic test_mov();
        do_cmd(0, LDI, 3'd1, 3'd0, 8'd30);
        do_cmd(0, LDI, 3'd3, 3'd0, 8'd54);
        set_cmd(0, MOV, 3'd2, 3'd3, 8'd0);
        tick();
        cmd_valid[0] = 1'b0;
        n_cmp++;
        if (stb(0) !== 7'b1000010) begin
            n_bad++; $display("FAIL mov_rsel got stb=%b want 1000010", stb(0));
        end
        tick();
        n_cmp++;
        if (stb(0) !== 7'b0100100 || d[0] !== 8'd54) begin
            n_bad++; $display("FAIL mov_wr got stb=%b d=%0d want 0100100 54", stb(0), d[0]);
        end
        tick();
        n_cmp++;
        if (cmd_ready[0] !== 1'b1 || stb(0) !== 7'b0) begin
            n_bad++; $display("FAIL mov_end got ready=%b stb=%b want 1 0", cmd_ready[0], stb(0));
        end
        set_cmd(0, RD, 3'd0, 3'd2, 8'd0);
        tick();
        cmd_valid[0] = 1'b0;
        n_cmp++;
        if (stb(0) !== 7'b1000100) begin
            n_bad++; $display("FAIL rd_c_rsel got stb=%b want 1000100", stb(0));
        end
        tick();
        n_cmp++;
        if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 8'd54) begin
            n_bad++; $display("FAIL rd_c_rsp got rv=%b data=%0d want 1 54", rsp_valid[0], rsp_data[0]);
        end
        tick();
    endtask

    task automatic test_rd_lat3();
        do_cmd(1, LDI, 3'd1, 3'd0, 8'd30);
        set_cmd(1, RD, 3'd0, 3'd1, 8'd0);
        tick();
        cmd_valid[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (stb(1) !== 7'b1001000 || cmd_ready[1] !== 1'b0 || rsp_valid[1] !== 1'b0) begin
                n_bad++; $display("FAIL lat3_rsel%0d got stb=%b ready=%b rv=%b want 1001000 0 0", k, stb(1), cmd_ready[1], rsp_valid[1]);
            end
            tick();
        end
        n_cmp++;
        if (rsp_valid[1] !== 1'b1 || rsp_data[1] !== 8'd30 || stb(1) !== 7'b0 || cmd_ready[1] !== 1'b0) begin
            n_bad++; $display("FAIL lat3_rsp got rv=%b data=%0d stb=%b ready=%b want 1 30 0 0", rsp_valid[1], rsp_data[1], stb(1), cmd_ready[1]);
        end
        tick();
        n_cmp++;
        if (rsp_valid[1] !== 1'b0 || cmd_ready[1] !== 1'b1) begin
            n_bad++; $display("FAIL lat3_end got rv=%b ready=%b want 0 1", rsp_valid[1], cmd_ready[1]);
        end
    endtask

    task automatic test_illegal();
        set_cmd(0, MOV, 3'd0, 3'd6, 8'd0);
        tick();
        cmd_valid[0] = 1'b0;
        n_cmp++;
        if (err[0] !== 1'b1 || stb(0) !== 7'b0 || cmd_ready[0] !== 1'b0) begin
            n_bad++; $display("FAIL ill_mov got err=%b stb=%b ready=%b want 1 0 0", err[0], stb(0), cmd_ready[0]);
        end
        tick();
        n_cmp++;
        if (err[0] !== 1'b0 || cmd_ready[0] !== 1'b1) begin
            n_bad++; $display("FAIL ill_mov_end got err=%b ready=%b want 0 1", err[0], cmd_ready[0]);
        end
        set_cmd(0, LDI, 3'd7, 3'd0, 8'h55);
        tick();
        cmd_valid[0] = 1'b0;
        n_cmp++;
        if (err[0] !== 1'b1 || stb(0) !== 7'b0 || d[0] !== 8'd0) begin
            n_bad++; $display("FAIL ill_ldi got err=%b stb=%b d=%0d want 1 0 0", err[0], stb(0), d[0]);
        end
        tick();
        n_cmp++;
        if (err[0] !== 1'b0 || cmd_ready[0] !== 1'b1) begin
            n_bad++; $display("FAIL ill_ldi_end got err=%b ready=%b want 0 1", err[0], cmd_ready[0]);
        end
        do_cmd(0, RD, 3'd0, 3'd0, 8'd0);
        n_cmp++;
        if (rsp_data[0] !== 8'd100 || err[0] !== 1'b0) begin
            n_bad++; $display("FAIL ill_a_kept got data=%0d err=%b want 100 0", rsp_data[0], err[0]);
        end
    endtask

    task automatic test_valid_held();
        set_cmd(0, LDI, 3'd4, 3'd0, 8'hFF);
        tick();
        cmd_op = RD; cmd_src = 3'd4; cmd_imm = 8'h11;
        n_cmp++;
        if (stb(0) !== 7'b0100001 || d[0] !== 8'hFF) begin
            n_bad++; $display("FAIL held_wr got stb=%b d=%0h want 0100001 ff", stb(0), d[0]);
        end
        tick();
        cmd_imm = 8'h22;
        n_cmp++;
        if (stb(0) !== 7'b0 || cmd_ready[0] !== 1'b1) begin
            n_bad++; $display("FAIL held_gap got stb=%b ready=%b want 0 1", stb(0), cmd_ready[0]);
        end
        tick();
        cmd_valid[0] = 1'b0;
        n_cmp++;
        if (stb(0) !== 7'b1000001 || cmd_ready[0] !== 1'b0) begin
            n_bad++; $display("FAIL held_rsel got stb=%b ready=%b want 1000001 0", stb(0), cmd_ready[0]);
        end
        tick();
        n_cmp++;
        if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 8'hFF) begin
            n_bad++; $display("FAIL held_rsp got rv=%b data=%0h want 1 ff", rsp_valid[0], rsp_data[0]);
        end
        tick();
        n_cmp++;
        if (stb(0) !== 7'b0 || rsp_valid[0] !== 1'b0 || cmd_ready[0] !== 1'b1) begin
            n_bad++; $display("FAIL held_end got stb=%b rv=%b ready=%b want 0 0 1", stb(0), rsp_valid[0], cmd_ready[0]);
        end
    endtask

    task automatic test_reset_mid();
        set_cmd(0, MOV, 3'd0, 3'd3, 8'd0);
        tick();
        cmd_valid[0] = 1'b0;
        n_cmp++;
        if (stb(0) !== 7'b1000010) begin
            n_bad++; $display("FAIL rstmid_rsel got stb=%b want 1000010", stb(0));
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (stb(0) !== 7'b0 || d[0] !== 8'd0 || cmd_ready[0] !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_abort got stb=%b d=%0d ready=%b want 0 0 0", stb(0), d[0], cmd_ready[0]);
        end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (cmd_ready !== 2'b11 || stb(0) !== 7'b0) begin
            n_bad++; $display("FAIL rstmid_ready got ready=%b stb=%b want 11 0", cmd_ready, stb(0));
        end
        do_cmd(0, RD, 3'd0, 3'd0, 8'd0);
        n_cmp++;
        if (rsp_data[0] !== 8'd100) begin
            n_bad++; $display("FAIL rstmid_a_kept got data=%0d want 100", rsp_data[0]);
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_mov();
        test_rd_lat3();
        test_illegal();
        test_valid_held();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
